// File: rtl/expu_arbiter.sv
// Round-robin front end sharing one EXPU among N_REQ requesters, with tag-based result return
// and a drain/clear flush sequencer. Optional per-requester beat counters: EXPU_ARB_STATS_EN.
module expu_arbiter #(
  parameter int N_REQ  = 4,
  parameter int N_ROWS = 1,
  parameter int WIDTH  = 16,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            enable_i,
  input  logic                            flush_i,
  output logic                            flush_done_o,
  input  logic [N_REQ-1:0]                req_valid_i,
  output logic [N_REQ-1:0]                req_ready_o,
  input  logic [N_REQ*N_ROWS-1:0]         req_strb_i,
  input  logic [N_REQ*N_ROWS*WIDTH-1:0]   req_op_i,
  output logic [N_REQ-1:0]                rsp_valid_o,
  input  logic [N_REQ-1:0]                rsp_ready_i,
  output logic [N_ROWS*WIDTH-1:0]         rsp_res_o,
  output logic [N_ROWS-1:0]               rsp_strb_o,
  output logic                            expu_enable_o,
  output logic                            expu_clear_o,
  output logic                            expu_valid_o,
  input  logic                            expu_ready_i,
  output logic [N_ROWS-1:0]               expu_strb_o,
  output logic [N_ROWS*WIDTH-1:0]         expu_op_o,
  output logic [ID_W-1:0]                 expu_tag_o,
  input  logic                            expu_valid_i,
  output logic                            expu_ready_o,
  input  logic [N_ROWS-1:0]               expu_strb_i,
  input  logic [N_ROWS*WIDTH-1:0]         expu_res_i,
  input  logic [ID_W-1:0]                 expu_tag_i,
  input  logic                            expu_busy_i
`ifdef EXPU_ARB_STATS_EN
  ,
  output logic [N_REQ*32-1:0]             stats_o
`endif
);

  localparam int BW = N_ROWS * WIDTH;
  localparam logic [ID_W:0] NREQ_W = (ID_W+1)'(N_REQ);

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR, DONE} state_t;

  state_t          state_reg, state_next;
  logic [ID_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic            locked_reg, locked_next;
  logic [ID_W-1:0] lock_id_reg, lock_id_next;
  logic            grant_vld;
  logic [ID_W-1:0] grant_id;
  logic            accept;
  logic [ID_W:0]   scan_idx;
  logic [ID_W:0]   ptr_inc;

  logic [BW-1:0]     op_arr   [N_REQ];
  logic [N_ROWS-1:0] strb_arr [N_REQ];
  logic [N_REQ-1:0]  tag_hit;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign op_arr[gi]      = req_op_i[gi*BW +: BW];
      assign strb_arr[gi]    = req_strb_i[gi*N_ROWS +: N_ROWS];
      assign req_ready_o[gi] = accept & (grant_id == ID_W'(gi));
      assign tag_hit[gi]     = (expu_tag_i == ID_W'(gi));
      assign rsp_valid_o[gi] = expu_valid_i & tag_hit[gi];
    end
  endgenerate

  // A stalled beat stays granted until it handshakes, independent of enable and FSM state.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    if (locked_reg) begin
      grant_vld = 1'b1;
      grant_id  = lock_id_reg;
    end else if (state_reg == RUN && enable_i) begin
      // Descending scan so the nearest requester after rr_ptr is the last writer.
      for (int i = N_REQ - 1; i >= 0; i--) begin
        scan_idx = {1'b0, rr_ptr_reg} + (ID_W+1)'(i);
        if (scan_idx >= NREQ_W) scan_idx = scan_idx - NREQ_W;
        if (req_valid_i[scan_idx[ID_W-1:0]]) begin
          grant_vld = 1'b1;
          grant_id  = scan_idx[ID_W-1:0];
        end
      end
    end
  end

  assign accept        = grant_vld & expu_ready_i;
  assign expu_valid_o  = grant_vld;
  assign expu_op_o     = op_arr[grant_id];
  assign expu_strb_o   = strb_arr[grant_id];
  assign expu_tag_o    = grant_id;
  assign expu_enable_o = enable_i;

  // A non-ready target stalls the whole EXPU output, so zero-latency routing is enough.
  assign expu_ready_o = |(tag_hit & rsp_ready_i);
  assign rsp_res_o    = expu_res_i;
  assign rsp_strb_o   = expu_strb_i;

  always_comb begin
    locked_next  = locked_reg;
    lock_id_next = lock_id_reg;
    rr_ptr_next  = rr_ptr_reg;
    ptr_inc      = {1'b0, grant_id} + (ID_W+1)'(1);
    if (grant_vld && !expu_ready_i) begin
      locked_next  = 1'b1;
      lock_id_next = grant_id;
    end else if (accept) begin
      locked_next  = 1'b0;
    end
    if (accept) begin
      rr_ptr_next = (ptr_inc >= NREQ_W) ? '0 : ptr_inc[ID_W-1:0];
    end else if (state_reg == CLEAR) begin
      rr_ptr_next = '0;
    end
  end

  always_comb begin
    state_next   = state_reg;
    expu_clear_o = 1'b0;
    flush_done_o = 1'b0;
    case (state_reg)
      RUN:   if (flush_i) state_next = DRAIN;
      DRAIN: if (!locked_reg && !expu_busy_i && !expu_valid_i) state_next = CLEAR;
      CLEAR: begin
        expu_clear_o = 1'b1;
        state_next   = DONE;
      end
      DONE: begin
        flush_done_o = 1'b1;
        state_next   = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= RUN;
      rr_ptr_reg  <= '0;
      locked_reg  <= 1'b0;
      lock_id_reg <= '0;
    end else begin
      state_reg   <= state_next;
      rr_ptr_reg  <= rr_ptr_next;
      locked_reg  <= locked_next;
      lock_id_reg <= lock_id_next;
    end
  end

`ifdef EXPU_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stats
      logic [31:0] cnt_reg;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          cnt_reg <= '0;
        end else if (state_reg == CLEAR) begin
          cnt_reg <= '0;
        end else if (accept && grant_id == ID_W'(gi) && cnt_reg != 32'hFFFF_FFFF) begin
          cnt_reg <= cnt_reg + 32'd1;
        end
      end
      assign stats_o[gi*32 +: 32] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_expu_arbiter.sv
// Scoreboard bench for expu_arbiter: stimulus pushes expected beats/results, a negedge monitor
// pops and compares on every EXPU-side handshake; FSM pulses are checked directly.
module tb_expu_arbiter;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        flush_done_o;
  logic [3:0]  req_valid_i = '0;
  logic [3:0]  req_ready_o;
  logic [3:0]  req_strb_i = 4'hF;
  logic [63:0] req_op_i = {16'h4400, 16'h3300, 16'h2200, 16'h1100};
  logic [3:0]  rsp_valid_o;
  logic [3:0]  rsp_ready_i = '0;
  logic [15:0] rsp_res_o;
  logic [0:0]  rsp_strb_o;
  logic        expu_enable_o;
  logic        expu_clear_o;
  logic        expu_valid_o;
  logic        expu_ready_i = 1'b0;
  logic [0:0]  expu_strb_o;
  logic [15:0] expu_op_o;
  logic [1:0]  expu_tag_o;
  logic        expu_valid_i = 1'b0;
  logic        expu_ready_o;
  logic [0:0]  expu_strb_i = 1'b1;
  logic [15:0] expu_res_i = '0;
  logic [1:0]  expu_tag_i = '0;
  logic        expu_busy_i = 1'b0;
`ifdef EXPU_ARB_STATS_EN
  logic [127:0] stats_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed { logic [1:0] tag; logic [15:0] op; } beat_t;
  typedef struct packed { logic [3:0] vld; logic [15:0] res; } rsp_t;
  beat_t beat_q[$];
  rsp_t  rsp_q[$];
  beat_t mon_b;
  rsp_t  mon_r;

  always #5 clk = ~clk;

  expu_arbiter dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .flush_i(flush_i),
    .flush_done_o(flush_done_o), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_strb_i(req_strb_i), .req_op_i(req_op_i), .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i), .rsp_res_o(rsp_res_o), .rsp_strb_o(rsp_strb_o),
    .expu_enable_o(expu_enable_o), .expu_clear_o(expu_clear_o),
    .expu_valid_o(expu_valid_o), .expu_ready_i(expu_ready_i), .expu_strb_o(expu_strb_o),
    .expu_op_o(expu_op_o), .expu_tag_o(expu_tag_o), .expu_valid_i(expu_valid_i),
    .expu_ready_o(expu_ready_o), .expu_strb_i(expu_strb_i), .expu_res_i(expu_res_i),
    .expu_tag_i(expu_tag_i), .expu_busy_i(expu_busy_i)
`ifdef EXPU_ARB_STATS_EN
    , .stats_o(stats_o)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [1:0] tag);
    beat_t b;
    b.tag = tag;
    b.op  = 16'h1100 * (16'(tag) + 16'd1);
    beat_q.push_back(b);
  endtask

  task automatic push_rsp(input logic [3:0] vld, input logic [15:0] res);
    rsp_t r;
    r.vld = vld;
    r.res = res;
    rsp_q.push_back(r);
  endtask

  // Monitor: every EXPU-side handshake consumes one expected entry.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (expu_valid_o && expu_ready_i) begin
        if (beat_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL beat_unexpected: got tag %0d op 0x%0h, required no beat", expu_tag_o, expu_op_o);
        end else begin
          mon_b = beat_q.pop_front();
          chk("beat_tag", 64'(expu_tag_o), 64'(mon_b.tag));
          chk("beat_op", 64'(expu_op_o), 64'(mon_b.op));
          chk("beat_req_ready", 64'(req_ready_o), 64'(4'b0001 << mon_b.tag));
        end
      end
      if (expu_valid_i && expu_ready_o) begin
        if (rsp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: got rsp_valid 0x%0h, required no handshake", rsp_valid_o);
        end else begin
          mon_r = rsp_q.pop_front();
          chk("rsp_valid", 64'(rsp_valid_o), 64'(mon_r.vld));
          chk("rsp_res", 64'(rsp_res_o), 64'(mon_r.res));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready_o), 64'h0);
    chk("rst_expu_valid", 64'(expu_valid_o), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'h0);
    chk("rst_clear", 64'(expu_clear_o), 64'h0);
    chk("rst_done", 64'(flush_done_o), 64'h0);
    chk("rst_expu_ready", 64'(expu_ready_o), 64'h0);
    step();
    rst_i = 1'b0;

    // enable_i low blocks grants
    req_valid_i = 4'hF;
    expu_ready_i = 1'b1;
    @(negedge clk);
    chk("en_off_valid", 64'(expu_valid_o), 64'h0);
    chk("en_off_fwd", 64'(expu_enable_o), 64'h0);
    step();

    // round-robin, 8 beats
    enable_i = 1'b1;
    for (int i = 0; i < 8; i++) push_beat(2'(i));
    @(negedge clk);
    chk("en_on_fwd", 64'(expu_enable_o), 64'h1);
    repeat (8) step();
    req_valid_i = 4'h0;
    expu_ready_i = 1'b0;

    // lock under stall
    req_valid_i = 4'b0110;
    @(negedge clk);
    chk("lock_tag0", 64'(expu_tag_o), 64'h1);
    chk("lock_valid", 64'(expu_valid_o), 64'h1);
    chk("lock_ready_low", 64'(req_ready_o), 64'h0);
    step();
    req_valid_i = 4'b1100;
    @(negedge clk);
    chk("lock_tag1", 64'(expu_tag_o), 64'h1);
    chk("lock_op1", 64'(expu_op_o), 64'h2200);
    step();
    @(negedge clk);
    chk("lock_tag2", 64'(expu_tag_o), 64'h1);
    step();
    expu_ready_i = 1'b1;
    push_beat(2'd1);
    push_beat(2'd2);
    push_beat(2'd3);
    @(negedge clk);
    chk("lock_release", 64'(req_ready_o), 64'h2);
    repeat (3) step();
    req_valid_i = 4'h0;
    expu_ready_i = 1'b0;

    // response routing with stalled target
    expu_valid_i = 1'b1;
    expu_tag_i = 2'd2;
    expu_res_i = 16'hBEEF;
    rsp_ready_i = 4'b0000;
    @(negedge clk);
    chk("route_valid", 64'(rsp_valid_o), 64'h4);
    chk("route_stall0", 64'(expu_ready_o), 64'h0);
    step();
    @(negedge clk);
    chk("route_stall1", 64'(expu_ready_o), 64'h0);
    step();
    rsp_ready_i = 4'b0100;
    push_rsp(4'b0100, 16'hBEEF);
    @(negedge clk);
    chk("route_go", 64'(expu_ready_o), 64'h1);
    step();
    expu_tag_i = 2'd0;
    expu_res_i = 16'h0C0D;
    rsp_ready_i = 4'hF;
    push_rsp(4'b0001, 16'h0C0D);
    step();
    expu_valid_i = 1'b0;
    rsp_ready_i = 4'h0;

    // flush drain: first move rr_ptr to 2
    req_valid_i = 4'b0010;
    expu_ready_i = 1'b1;
    push_beat(2'd1);
    step();
    req_valid_i = 4'h0;
    flush_i = 1'b1;
    expu_busy_i = 1'b1;
    step();
    flush_i = 1'b0;
    req_valid_i = 4'hF;
    expu_tag_i = 2'd1;
    expu_res_i = 16'h1111;
    rsp_ready_i = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      expu_valid_i = (c == 1);
      if (c == 1) push_rsp(4'b0010, 16'h1111);
      @(negedge clk);
      chk("drain_ready", 64'(req_ready_o), 64'h0);
      chk("drain_clear", 64'(expu_clear_o), 64'h0);
      step();
    end
    expu_valid_i = 1'b0;
    expu_busy_i = 1'b0;
    rsp_ready_i = 4'h0;
    @(negedge clk);
    chk("drain_last_clear", 64'(expu_clear_o), 64'h0);
    step();
    @(negedge clk);
    chk("clear_pulse", 64'(expu_clear_o), 64'h1);
    chk("clear_done", 64'(flush_done_o), 64'h0);
    chk("clear_ready", 64'(req_ready_o), 64'h0);
    step();
    @(negedge clk);
    chk("done_pulse", 64'(flush_done_o), 64'h1);
    chk("done_clear", 64'(expu_clear_o), 64'h0);
    chk("done_ready", 64'(req_ready_o), 64'h0);
    push_beat(2'd0);
    step();
    @(negedge clk);
    chk("restart_tag", 64'(expu_tag_o), 64'h0);
    step();
    req_valid_i = 4'h0;

    // flush coincident with an accepted beat from requester 3
    req_valid_i = 4'b1000;
    flush_i = 1'b1;
    push_beat(2'd3);
    step();
    flush_i = 1'b0;
    req_valid_i = 4'h0;
    expu_busy_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("fvb_busy_clear", 64'(expu_clear_o), 64'h0);
      step();
    end
    expu_busy_i = 1'b0;
    expu_valid_i = 1'b1;
    expu_tag_i = 2'd3;
    expu_res_i = 16'h3333;
    rsp_ready_i = 4'b1000;
    push_rsp(4'b1000, 16'h3333);
    @(negedge clk);
    chk("fvb_rsp_clear", 64'(expu_clear_o), 64'h0);
    step();
    expu_valid_i = 1'b0;
    rsp_ready_i = 4'h0;
    @(negedge clk);
    chk("fvb_wait_clear", 64'(expu_clear_o), 64'h0);
    step();
    @(negedge clk);
    chk("fvb_clear", 64'(expu_clear_o), 64'h1);
    step();
    @(negedge clk);
    chk("fvb_done", 64'(flush_done_o), 64'h1);
    step();

    // reset during DRAIN
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    req_valid_i = 4'hF;
    expu_busy_i = 1'b1;
    @(negedge clk);
    chk("rd_drain_ready", 64'(req_ready_o), 64'h0);
    req_valid_i = 4'h0;
    expu_busy_i = 1'b0;
    #1;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rd_no_done", 64'(flush_done_o), 64'h0);
      chk("rd_no_clear", 64'(expu_clear_o), 64'h0);
      chk("rd_ready_idle", 64'(req_ready_o), 64'h0);
      step();
    end
    // five beats from requester 1 right after reset
    req_valid_i = 4'b0010;
    expu_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) push_beat(2'd1);
    @(negedge clk);
    chk("rd_grant", 64'(req_ready_o), 64'h2);
    repeat (5) step();
    req_valid_i = 4'h0;
`ifdef EXPU_ARB_STATS_EN
    @(negedge clk);
    chk("stats_req1", 64'(stats_o[63:32]), 64'd5);
    chk("stats_req0", 64'(stats_o[31:0]), 64'd0);
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("stats_flushed", 64'(stats_o[63:32]), 64'd0);
`endif

    repeat (2) step();
    chk("beat_q_empty", 64'(beat_q.size()), 64'd0);
    chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/expu_arbiter.md
Name: expu_arbiter

Overview:
- Shares one expu_top instance between N_REQ independent requesters.
- Arbitrates input vectors round-robin and tags each beat with the requester index through the EXPU tag path.
- Routes each result back to its originator by that tag.
- Includes a flush sequencer that drains the EXPU pipeline and pulses its clear before the softmax datapath starts a new job.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- N_ROWS, 1, rows per beat; matches the EXPU N_ROWS.
- WIDTH, 16, element width; matches fp_width(FPFORMAT).
- ID_W, $clog2(N_REQ), tag width driven to and from the EXPU TAG_TYPE.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- enable_i  in  1  global enable; forwarded to expu_enable_o; gates new grants
- flush_i  in  1  flush request pulse
- flush_done_o  out  1  one-cycle pulse when flush completes
- req_valid_i  in  N_REQ  per-requester valid
- req_ready_o  out  N_REQ  per-requester ready (one-hot or zero)
- req_strb_i  in  N_REQ*N_ROWS  per-requester row strobes
- req_op_i  in  N_REQ*N_ROWS*WIDTH  per-requester operands
- rsp_valid_o  out  N_REQ  per-requester result valid
- rsp_ready_i  in  N_REQ  per-requester result ready
- rsp_res_o  out  N_ROWS*WIDTH  result data, broadcast to all requesters
- rsp_strb_o  out  N_ROWS  result strobes, broadcast
- expu_enable_o  out  1  to EXPU enable_i
- expu_clear_o  out  1  to EXPU clear_i
- expu_valid_o / expu_ready_i / expu_strb_o / expu_op_o / expu_tag_o  out/in/out/out/out  1/1/N_ROWS/N_ROWS*WIDTH/ID_W  EXPU input side
- expu_valid_i / expu_ready_o / expu_strb_i / expu_res_i / expu_tag_i  in/out/in/in/in  1/1/N_ROWS/N_ROWS*WIDTH/ID_W  EXPU output side
- expu_busy_i  in  1  EXPU busy_o

Behaviour:
- **Reset:** state RUN, rr_ptr=0, locked=0. All outputs 0 except rsp_res_o, rsp_strb_o and expu_op_o/expu_strb_o/expu_tag_o, which are don't-care data.
- **Grant:** combinational. In RUN with enable_i=1 and locked=0, grant = first k with req_valid_i[k]=1, scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
- **Input path:** expu_valid_o=1 when a grant exists. expu_op_o, expu_strb_o and expu_tag_o=k are taken from requester k. req_ready_o[k] = expu_ready_i & grant[k].
- **Lock:**
  - If expu_valid_o=1 and expu_ready_i=0, register locked=1 and lock_id=k.
  - While locked, grant is forced to lock_id regardless of rr_ptr or state, until the handshake completes.
  - Locked grant also ignores enable_i.
  - The requester must hold valid and data stable; the arbiter guarantees the same stability toward the EXPU.
- **Pointer:** on each accepted beat (expu_valid_o & expu_ready_i), rr_ptr <= k+1, wrapping N_REQ-1 -> 0. No change otherwise.
- **Output path:**
  - rsp_valid_o[j] = expu_valid_i & (expu_tag_i==j).
  - expu_ready_o = rsp_ready_i[expu_tag_i].
  - Results pass through with zero latency. A non-ready target stalls the whole EXPU, by design.
- **Latency:** arbiter adds 0 cycles on both paths.
- **expu_enable_o** = enable_i.
- **FSM states:** RUN, DRAIN, CLEAR, DONE.
  - RUN -> DRAIN on flush_i=1.
  - DRAIN: no new grants. A locked beat still completes. Results still route.
  - DRAIN -> CLEAR when locked=0 & expu_busy_i=0 & expu_valid_i=0.
  - CLEAR: expu_clear_o=1 for exactly one cycle; rr_ptr <= 0.
  - CLEAR -> DONE. DONE: flush_done_o=1 for one cycle.
  - DONE -> RUN.
  - flush_i outside RUN is ignored.
- **Simultaneous events:** flush_i in the same cycle as an accepted beat: the beat is accepted and the pointer updates; DRAIN then waits for that beat to exit the EXPU.
- **Reset mid-flush:** returns to RUN with no flush_done_o pulse.
- **enable_i=0:** no new grants, but the FSM still advances.

Optional Feature:
- **Macro:** EXPU_ARB_STATS_EN.
- **Defined:**
  - Adds output stats_o (N_REQ*32): per-requester count of accepted beats.
  - Counters saturate at 2^32-1.
  - Cleared on rst_i and in state CLEAR.
  - Update on the same edge as the handshake.
- **Undefined:** port and counters absent; all other behaviour identical.

Test Plan:
- **Round-robin:** N_REQ=4, all req_valid_i=1, expu_ready_i=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3; each expu_tag_o matches.
- **Lock under stall:** rr_ptr=0, req_valid_i=0b0110, expu_ready_i low 3 cycles, then req_valid_i[1] drops to 0 and req_valid_i[3]=1 -> grant held on 1 with expu_op_o stable; on ready, beat from 1 accepted, next grant 2.
- **Response routing:** EXPU returns tag=2 with rsp_ready_i=0b0000 for 2 cycles, then 0b0100 -> only rsp_valid_o[2]=1; expu_ready_o=0 then 1; handshake on 3rd cycle.
- **Flush drain:** 3 beats in flight (expu_busy_i=1 for 4 cycles), flush_i pulse -> req_ready_o=0 throughout; expu_clear_o pulses 1 cycle after busy and valid drop; flush_done_o next cycle; next grant starts from requester 0.
- **Flush vs accepted beat:** flush_i coincides with an accepted beat from requester 3 -> beat accepted; CLEAR only after its result handshakes.
- **Reset during DRAIN, and stats:** rst_i asserted during DRAIN -> state RUN, no flush_done_o, all req_ready_o=0 until grant. With EXPU_ARB_STATS_EN, 5 beats from requester 1 -> stats_o[1]=5; after flush -> 0.
